// File: rtl/imem_pkg.sv
// Shared constants and types for the loadable instruction memory.
// The all-zero word doubles as the HALT opcode and the value of unwritten words.
package imem_pkg;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  // Fetch and load addresses are byte addresses of halfwords; bit 0 is dropped for the word index.
  localparam int WORD_LSB = 1;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W word storage with per-word written bits, one write port
// and one registered read port that returns HALT for unwritten or killed reads.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rkill,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  // Storage itself is never reset; only the written bits are, so old contents read as HALT.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else if (we) begin
      written[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (rkill || !written[raddr]) ? DATA_W'(HALT_WORD) : mem[raddr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: filled through the load port in LOAD, serves
// one-cycle fetches in RUN, and stops fetching once a HALT word is delivered.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              oob,
  output logic              halted
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

  state_t state_q;

  logic [ADDR_W-2:0] fetch_word;
  logic [ADDR_W-2:0] load_word;
  logic              fetch_in_range;
  logic              load_in_range;
  logic              fetch_mis;
  logic              halt_now;
  logic              accept;
  logic              wr_en;

  assign fetch_word     = fetch_addr[ADDR_W-1:WORD_LSB];
  assign load_word      = load_addr[ADDR_W-1:WORD_LSB];
  assign fetch_in_range = {1'b0, fetch_word} < DEPTH_L;
  assign load_in_range  = {1'b0, load_word} < DEPTH_L;
  assign fetch_mis      = fetch_addr[0];

  // A HALT result sitting in the output registers counts as halted right away,
  // and it also blocks any further fetch while the FSM moves to HALTED.
  assign halt_now = (state_q == S_RUN) && instr_valid && (instr == DATA_W'(HALT_WORD));
  assign halted   = (state_q == S_HALTED) || halt_now;

  assign accept = (state_q == S_RUN) && fetch_req && !stall && !load_en && !halt_now;
  assign wr_en  = (state_q == S_LOAD) && load_we && !load_addr[0] && load_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else if (load_en) begin
      state_q <= S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:   state_q <= S_RUN;
        S_RUN:    state_q <= halt_now ? S_HALTED : S_RUN;
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_LOAD;
      endcase
    end
  end

  // The loader discards any in-flight result; a stall freezes the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      oob         <= 1'b0;
    end else if (load_en) begin
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      oob         <= 1'b0;
    end else if (!stall) begin
      instr_valid <= accept;
      misaligned  <= accept && fetch_mis;
      oob         <= accept && !fetch_mis && !fetch_in_range;
    end
  end

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (load_word[IDX_W-1:0]),
    .wdata (load_data),
    .re    (accept),
    .rkill (fetch_mis || !fetch_in_range),
    .raddr (fetch_word[IDX_W-1:0]),
    .rdata (instr)
  );

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: stimulus pushes expected fetch results,
// a monitor pops them whenever a fresh result is presented.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_en = 1'b1;
  logic        load_we = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        stall = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        misaligned;
  logic        oob;
  logic        halted;

  typedef struct packed {
    logic [15:0] instr;
    logic        mis;
    logic        oob;
    logic        halted;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  imem_loadable #(.ADDR_W(16), .DATA_W(16), .DEPTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .oob         (oob),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic le, input logic we, input logic [15:0] la,
                               input logic [15:0] ld, input logic fr, input logic [15:0] fa,
                               input logic st);
    load_en    = le;
    load_we    = we;
    load_addr  = la;
    load_data  = ld;
    fetch_req  = fr;
    fetch_addr = fa;
    stall      = st;
    step();
  endtask

  task automatic loadWord(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic fetchWord(input logic [15:0] a, input logic [15:0] e_instr,
                           input logic e_mis, input logic e_oob, input logic e_halt);
    expq.push_back('{instr: e_instr, mis: e_mis, oob: e_oob, halted: e_halt});
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, a, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic reload();
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checkOutput("halted_clear_on_load", 32'(halted), 32'd0);
    checkOutput("valid_clear_on_load", 32'(instr_valid), 32'd0);
  endtask

  // A fresh result is one registered on an unstalled edge while out of reset.
  initial begin : monitor
    logic stall_s;
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      stall_s = stall;
      rst_s   = rst_n;
      #1;
      if (rst_n && rst_s && !stall_s && instr_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", {16'h0, instr}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          checkOutput("sb_instr", 32'(instr), 32'(e.instr));
          checkOutput("sb_misaligned", 32'(misaligned), 32'(e.mis));
          checkOutput("sb_oob", 32'(oob), 32'(e.oob));
          checkOutput("sb_halted", 32'(halted), 32'(e.halted));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset_instr", 32'(instr), 32'h0);
    checkOutput("reset_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset_misaligned", 32'(misaligned), 32'd0);
    checkOutput("reset_oob", 32'(oob), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    step();

    // Program load, plus writes that must be dropped (would alias to words 0 and 1).
    loadWord(16'h0000, 16'hFE21);
    loadWord(16'h0002, 16'hFB22);
    loadWord(16'h0004, 16'h0000);
    loadWord(16'h0041, 16'h1111);
    loadWord(16'h0040, 16'h2222);
    loadWord(16'h0003, 16'h3333);
    idle(1);

    fetchWord(16'h0000, 16'hFE21, 1'b0, 1'b0, 1'b0);
    fetchWord(16'h0002, 16'hFB22, 1'b0, 1'b0, 1'b0);
    fetchWord(16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    checkOutput("halt_valid_drop", 32'(instr_valid), 32'd0);
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0002, 1'b0);
    checkOutput("halt_ignores_fetch", 32'(instr_valid), 32'd0);
    checkOutput("halt_instr_kept", 32'(instr), 32'h0);

    reload();
    idle(1);
    fetchWord(16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle(1);

    reload();
    idle(1);
    fetchWord(16'h0040, 16'h0000, 1'b0, 1'b1, 1'b1);
    idle(1);

    // Stall holds the first result while the next request waits.
    reload();
    idle(1);
    fetchWord(16'h0000, 16'hFE21, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0002, 1'b1);
      checkOutput("stall_instr_hold", 32'(instr), 32'hFE21);
      checkOutput("stall_valid_hold", 32'(instr_valid), 32'd1);
    end
    fetchWord(16'h0002, 16'hFB22, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("idle_valid_drop", 32'(instr_valid), 32'd0);
    checkOutput("idle_instr_kept", 32'(instr), 32'hFB22);

    fetchWord(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    reload();
    loadWord(16'h0010, 16'hF564);
    idle(1);
    fetchWord(16'h0010, 16'hF564, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset mid-stream; written bits are lost.
    fetchWord(16'h0000, 16'hFE21, 1'b0, 1'b0, 1'b0);
    fetch_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_instr", 32'(instr), 32'h0);
    checkOutput("async_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("async_rst_halted", 32'(halted), 32'd0);
    checkOutput("async_rst_misaligned", 32'(misaligned), 32'd0);
    checkOutput("async_rst_oob", 32'(oob), 32'd0);
    load_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    idle(1);
    fetchWord(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(2);

    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
